// File: rtl/tilemap_access_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------------------+
// | tilemap_access_arbiter: single-port tilemap RAM arbiter, display > writes > reads.   |
// | Optional stall/drop statistics ports under TILEMAP_ARB_STATS_EN.  Rev 1.0             |
// +--------------------------------------------------------------------------------------+
module tilemap_access_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 13,
  parameter int TILE_W     = 9
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              disp_req,
  input  logic [3:0]        disp_stage,
  input  logic [3:0]        disp_row,
  input  logic [4:0]        disp_col,
  output logic              disp_rvalid,
  output logic [TILE_W-1:0] disp_tile,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [3:0]        wr_stage,
  input  logic [3:0]        wr_row,
  input  logic [4:0]        wr_col,
  input  logic [TILE_W-1:0] wr_tile,
  output logic              wr_drop,
  input  logic              lr_valid,
  output logic              lr_ready,
  input  logic [3:0]        lr_stage,
  input  logic [3:0]        lr_row,
  input  logic [4:0]        lr_col,
  output logic              lr_rvalid,
  output logic [TILE_W-1:0] lr_tile,
  output logic [4:0]        fifo_level,
`ifdef TILEMAP_ARB_STATS_EN
  output logic [15:0]       stall_cycles,
  output logic [7:0]        drop_count,
`endif
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [TILE_W-1:0] ram_wdata,
  input  logic [TILE_W-1:0] ram_rdata
);

  localparam int         PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int         ENT_W  = ADDR_W + TILE_W;
  localparam logic [4:0] C_FULL = 5'(FIFO_DEPTH);

  function automatic logic [ADDR_W-1:0] flat_addr(input logic [3:0] s, input logic [3:0] r,
                                                  input logic [4:0] c);
    return ADDR_W'(s) * ADDR_W'(300) + ADDR_W'(r) * ADDR_W'(20) + ADDR_W'(c);
  endfunction

  function automatic logic in_range(input logic [3:0] r, input logic [4:0] c);
    return (r < 4'd15) && (c < 5'd20);
  endfunction

  logic [ADDR_W-1:0] w_disp_addr, w_wr_addr, w_lr_addr;
  logic              w_disp_ok, w_wr_ok;
  logic              w_empty, w_full, w_push, w_pop, w_lr_issue, w_wr_bad;
  logic [ENT_W-1:0]  w_head;
  logic [TILE_W-1:0] w_disp_data;

  logic [ENT_W-1:0]  r_fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr, r_wr_ptr;
  logic [4:0]        r_level;
  logic              r_disp_p1, r_disp_bad_p1, r_disp_bad_p2, r_lr_p1;
  logic [TILE_W-1:0] r_disp_hold, r_lr_hold;

  assign w_disp_addr = flat_addr(disp_stage, disp_row, disp_col);
  assign w_wr_addr   = flat_addr(wr_stage, wr_row, wr_col);
  assign w_lr_addr   = flat_addr(lr_stage, lr_row, lr_col);
  assign w_disp_ok   = in_range(disp_row, disp_col);
  assign w_wr_ok     = in_range(wr_row, wr_col);

  assign w_empty    = (r_level == 5'd0);
  assign w_full     = (r_level == C_FULL);
  assign wr_ready   = !w_full;
  // Reads wait for an empty FIFO so they can never overtake a buffered write.
  assign lr_ready   = !disp_req && w_empty;
  assign w_push     = wr_valid && wr_ready && w_wr_ok;
  assign w_wr_bad   = wr_valid && wr_ready && !w_wr_ok;
  assign w_pop      = !disp_req && !w_empty;
  assign w_lr_issue = lr_valid && lr_ready;
  assign w_head     = r_fifo_mem[r_rd_ptr];
  assign fifo_level = r_level;

  always_ff @(posedge clk) begin
    if (w_push) r_fifo_mem[r_wr_ptr] <= {w_wr_addr, wr_tile};
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_level       <= '0;
      ram_addr      <= '0;
      ram_we        <= 1'b0;
      ram_wdata     <= '0;
      r_disp_p1     <= 1'b0;
      r_disp_bad_p1 <= 1'b0;
      r_disp_bad_p2 <= 1'b0;
      r_lr_p1       <= 1'b0;
      disp_rvalid   <= 1'b0;
      lr_rvalid     <= 1'b0;
      wr_drop       <= 1'b0;
      r_disp_hold   <= '0;
      r_lr_hold     <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 5'd1;
        2'b01:   r_level <= r_level - 5'd1;
        default: r_level <= r_level;
      endcase

      if (disp_req) begin
        ram_addr <= w_disp_addr;
        ram_we   <= 1'b0;
      end else if (w_pop) begin
        ram_addr  <= w_head[ENT_W-1:TILE_W];
        ram_wdata <= w_head[TILE_W-1:0];
        ram_we    <= 1'b1;
      end else begin
        ram_we <= 1'b0;
        if (w_lr_issue) ram_addr <= w_lr_addr;
      end

      r_disp_p1     <= disp_req;
      r_disp_bad_p1 <= disp_req && !w_disp_ok;
      r_lr_p1       <= w_lr_issue;
      disp_rvalid   <= r_disp_p1;
      r_disp_bad_p2 <= r_disp_bad_p1;
      lr_rvalid     <= r_lr_p1;
      wr_drop       <= w_wr_bad;

      if (disp_rvalid) r_disp_hold <= w_disp_data;
      if (lr_rvalid)   r_lr_hold   <= ram_rdata;
    end
  end

  // RAM data arrives in the rvalid cycle; the hold registers keep it stable afterwards.
  assign w_disp_data = r_disp_bad_p2 ? '0 : ram_rdata;
  assign disp_tile   = disp_rvalid ? w_disp_data : r_disp_hold;
  assign lr_tile     = lr_rvalid ? ram_rdata : r_lr_hold;

`ifdef TILEMAP_ARB_STATS_EN
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      stall_cycles <= '0;
      drop_count   <= '0;
    end else begin
      if (wr_valid && !wr_ready && (stall_cycles != 16'hFFFF)) stall_cycles <= stall_cycles + 16'd1;
      if (wr_drop && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
    end
  end
`endif

endmodule
`default_nettype wire
